// File: rtl/piso_bit_feeder_pkg.sv
// rtl/piso_bit_feeder_pkg.sv - shared types and defaults for the serial bit feeder
package piso_bit_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int   DEF_WIDTH      = 8;
    localparam int   DEF_BIT_DIV    = 1;
    localparam bit   DEF_MSB_FIRST  = 1'b1;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_feeder_if.sv
// rtl/piso_bit_feeder_if.sv - parallel word handshake into the bit feeder
interface piso_bit_feeder_if #(
    parameter int WIDTH = piso_bit_feeder_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/piso_bit_feeder_bit_tick_gen.sv
// rtl/piso_bit_feeder_bit_tick_gen.sv - per-bit cycle divider with restart
module piso_bit_feeder_bit_tick_gen
    import piso_bit_feeder_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic strobe_o,
    output logic last_o,
    output logic last_next_o
);
    localparam int            CW     = cnt_width(BIT_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(BIT_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;

    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (load_i) begin
            cnt_d    = RELOAD;
            strobe_d = 1'b1;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o    = strobe_q;
    assign last_o      = (cnt_q == '0);
    // Lookahead lets the parent register a pulse that lines up with the last cycle.
    assign last_next_o = (cnt_d == '0);

endmodule

// File: rtl/piso_bit_feeder.sv
// rtl/piso_bit_feeder.sv - double-buffered parallel-to-serial feeder for the detector input
module piso_bit_feeder
    import piso_bit_feeder_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter bit   MSB_FIRST  = DEF_MSB_FIRST,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL,
    parameter int   BIT_DIV    = DEF_BIT_DIV
) (
    input  logic               clk,
    input  logic               rst,
    piso_bit_feeder_if.slave   s_if,
    output logic               dout_o,
    output logic               bit_valid_o,
    output logic               bit_strobe_o,
    output logic               word_done_o,
    output logic               busy_o
);
    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             dout_q, dout_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;

    logic ready;
    logic transfer;
    logic tick_load, tick_run;
    logic tick_strobe, tick_last, tick_last_next;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign ready       = !hold_valid_q && !rst;
    assign s_if.s_ready = ready;
    assign transfer    = s_if.s_valid && ready;

    piso_bit_feeder_bit_tick_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tick_load),
        .run_i       (tick_run),
        .strobe_o    (tick_strobe),
        .last_o      (tick_last),
        .last_next_o (tick_last_next)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        tick_load    = 1'b0;
        tick_run     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    shift_d   = s_if.s_data;
                    bit_cnt_d = LAST_IDX;
                    tick_load = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick_last && (bit_cnt_q == '0)) begin
                    // Word boundary: chain the next word in without an idle cycle when one is available.
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        bit_cnt_d    = LAST_IDX;
                        tick_load    = 1'b1;
                    end else if (transfer) begin
                        shift_d   = s_if.s_data;
                        bit_cnt_d = LAST_IDX;
                        tick_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (tick_last) begin
                        shift_d   = advance(shift_q);
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tick_load = 1'b1;
                    end else begin
                        tick_run = 1'b1;
                    end
                    if (transfer) begin
                        hold_d       = s_if.s_data;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dout_d      = (state_d == ST_SHIFT) ? head_bit(shift_d) : IDLE_LEVEL;
        bit_valid_d = (state_d == ST_SHIFT);
        word_done_d = (state_d == ST_SHIFT) && (bit_cnt_d == '0) && tick_last_next;
        busy_d      = (state_d == ST_SHIFT) || hold_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            dout_q       <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            bit_valid_q  <= bit_valid_d;
            word_done_q  <= word_done_d;
            busy_q       <= busy_d;
        end
    end

    assign dout_o       = dout_q;
    assign bit_valid_o  = bit_valid_q;
    assign bit_strobe_o = tick_strobe;
    assign word_done_o  = word_done_q;
    assign busy_o       = busy_q;

endmodule
